// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and select sequencer for the 4:1 data-flow multiplexer.
// Exactly one requester owns the shared mux output at a time. A requester
// keeps its grant while it holds req. If other requesters are waiting, its
// tenure ends after MAX_HOLD cycles. On every new grant the search pointer
// moves past the winner, so all four requesters are served in turn.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles while another request waits
//              (1..255)
//   CNT_W    : width of the tenure counter; must be able to hold MAX_HOLD
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   req   : level-sensitive request, one bit per requester
//   gnt   : registered one-hot grant, 0000 when idle
//   sel   : registered mux select for the current or last owner. The index
//           is bit-reversed because sel[0] is the mux's high-order select bit.
//   owner : registered binary index of the current or last owner
//   busy  : registered, high while any grant is active
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [1:0] owner,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [3:0]       others;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_next;
    logic             load;
    logic [1:0]       load_idx;

    // Returns {found, index} of the first set bit of r, searching from
    // 'start' upward, modulo 4. The loop walks the search order backwards,
    // so the closest candidate is the last one written and therefore wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The candidate search covers only the other requesters. The owner's
    // own request decides whether it keeps the grant. It must never count
    // as a competitor for a hand-off or for a forced rotation.
    always_comb begin
        others    = req & ~(4'b0001 << owner_q);
        pick_idle = rr_pick(req, ptr_q);
        pick_next = rr_pick(others, owner_q + 2'd1);
    end

    // Next-state and next-output logic. Every path that starts a new
    // tenure sets 'load'. The shared block after the case statement then
    // loads the grant, select, owner, pointer and tenure counter in one
    // place. A hand-off therefore switches gnt directly, with no 0000 cycle.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        load     = 1'b0;
        load_idx = 2'd0;

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (pick_idle[2]) begin
                    load     = 1'b1;
                    load_idx = pick_idle[1:0];
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    if (pick_next[2]) begin
                        load     = 1'b1;
                        load_idx = pick_next[1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = '0;
                    end
                end else if (hold_q < MAX_CNT) begin
                    hold_d = hold_q + ONE_CNT;
                end else if (pick_next[2]) begin
                    load     = 1'b1;
                    load_idx = pick_next[1:0];
                end else begin
                    // Nobody else is waiting. The owner keeps the grant and
                    // the counter stays saturated, so a newcomer preempts it
                    // on the next edge.
                    hold_d = MAX_CNT;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        if (load) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << load_idx;
            sel_d   = {load_idx[0], load_idx[1]};
            owner_d = load_idx;
            ptr_d   = load_idx + 2'd1;
            hold_d  = ONE_CNT;
        end

        busy_d = |gnt_d;
    end

    // State and output registers. Reset is synchronous, so it takes effect
    // on the next rising edge even in the middle of a tenure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            owner_q <= 2'b00;
            busy_q  <= 1'b0;
            ptr_q   <= 2'b00;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed bench for mux4_rr_arbiter with MAX_HOLD = 4. Each stimulus cycle
// drives req/rst on the falling edge. It also queues the register values
// expected after the following rising edge. A separate monitor samples the
// outputs 1 time unit after every rising edge and compares them against the
// head of the queue.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] owner;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [1:0] owner;
        logic       busy;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    mux4_rr_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .owner(owner),
        .busy (busy)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one output field against its expected value and counts the
    // comparison.
    task automatic checkOutput(input string nm, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, actual, expected);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and queues the outputs
    // expected after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [3:0] eg, input logic [1:0] es,
                                 input logic [1:0] eo, input logic eb,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        e.gnt   = eg;
        e.sel   = es;
        e.owner = eo;
        e.busy  = eb;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, checks the DUT against the oldest
    // queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.name, ".gnt"},   8'(gnt),   8'(e.gnt));
                checkOutput({e.name, ".sel"},   8'(sel),   8'(e.sel));
                checkOutput({e.name, ".owner"}, 8'(owner), 8'(e.owner));
                checkOutput({e.name, ".busy"},  8'(busy),  8'(e.busy));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [3:0] rr_gnt [5];
        logic [1:0] rr_sel [5];
        logic [1:0] rr_own [5];
        int         wait_cycles;

        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_sel = '{2'b00,   2'b10,   2'b01,   2'b11,   2'b00};
        rr_own = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd0};

        rst = 1'b1;
        req = 4'b1111;

        // Reset holds every output at zero, even with all requests high.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset0");
        applyStimulus(1'b1, 4'b1111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset1");

        // Reset is released. One edge later requester 0 wins (ptr=0).
        applyStimulus(1'b0, 4'b1111, 4'b0001, 2'b00, 2'd0, 1'b1, "first_grant");

        // Full contention: tenures of 4 cycles, owners 0,1,2,3,0, no bubble.
        // Owner 0 has already used one cycle of its first tenure.
        for (int r = 0; r < 5; r++) begin
            for (int c = (r == 0) ? 1 : 0; c < 4; c++) begin
                applyStimulus(1'b0, 4'b1111, rr_gnt[r], rr_sel[r], rr_own[r],
                              1'b1, $sformatf("contend_r%0d_c%0d", r, c));
            end
        end

        // Uncontended hold: owner 0 drops its request and requester 2 takes
        // over. Requester 2 then keeps the grant well past MAX_HOLD.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'b0100, 4'b0100, 2'b01, 2'd2, 1'b1,
                          $sformatf("hold2_c%0d", c));
        end

        // Release to idle: sel and owner keep their last values.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b01, 2'd2, 1'b0, "release_idle");

        // Pointer fairness: ptr=3, so the search order 3,0 picks requester 0,
        // not requester 2.
        applyStimulus(1'b0, 4'b0101, 4'b0001, 2'b00, 2'd0, 1'b1, "ptr_fair");

        // Hand-off from owner 0 to requester 1, then one more cycle held.
        applyStimulus(1'b0, 4'b1010, 4'b0010, 2'b10, 2'd1, 1'b1, "to_owner1");
        applyStimulus(1'b0, 4'b1010, 4'b0010, 2'b10, 2'd1, 1'b1, "owner1_hold");

        // Zero-bubble hand-off: requester 1 drops its request, requester 3
        // gets the grant on the same edge.
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'b11, 2'd3, 1'b1, "zero_bubble");

        // Owner 3 reaches hold_cnt=2, then reset mid-grant.
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'b11, 2'd3, 1'b1, "owner3_hold2");
        applyStimulus(1'b1, 4'b1000, 4'b0000, 2'b00, 2'd0, 1'b0, "mid_reset");

        // Reset released: requester 3 is granted again one edge later.
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'b11, 2'd3, 1'b1, "regrant3");

        // Fresh tenure: with requester 0 now waiting, owner 3 keeps the grant
        // for three more cycles (4 in total) before it rotates to 0.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1001, 4'b1000, 2'b11, 2'd3, 1'b1,
                          $sformatf("fresh_tenure_c%0d", c));
        end
        applyStimulus(1'b0, 4'b1001, 4'b0001, 2'b00, 2'd0, 1'b1, "rotate_to0");

        // All requests drop: the arbiter goes idle.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0, "final_idle");

        // Wait (bounded) for the monitor to consume every expectation.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
